// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle sequencer: state and trap-cause encodings,
// the RV32I opcodes the sequencer accepts, and the legality check over them.
package ctrl_pkg;

   typedef enum logic [3:0] {
      ST_F_REQ  = 4'd0,
      ST_F_WAIT = 4'd1,
      ST_DEC    = 4'd2,
      ST_EXEC   = 4'd3,
      ST_M_REQ  = 4'd4,
      ST_M_WAIT = 4'd5,
      ST_WB     = 4'd6,
      ST_HALT   = 4'd7,
      ST_TRAP   = 4'd8
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_ILLEGAL = 2'b01,
      CAUSE_IMEM_TO = 2'b10,
      CAUSE_DMEM_TO = 2'b11
   } trap_cause_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   function automatic logic is_legal_opcode(input logic [6:0] opc);
      logic legal;
      case (opc)
         OPC_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH,
         OPC_OP_IMM, OPC_JALR, OPC_JAL, OPC_LUI: legal = 1'b1;
         default:                                legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Memory-access watchdog: counts cycles while enabled, cleared at the start of
// each access, and flags expiry once MAX_CYCLES-1 has been reached.
module seq_timeout_cnt #(
   parameter int MAX_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign expired_o = (cnt_q == W'(MAX_CYCLES - 1));

   // Saturates at the expiry value so a held enable cannot wrap back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle RV32I sequencer: fetch/decode/execute/memory/writeback with
// req/gnt/rvalid handshakes, one-cycle datapath strobes and sticky traps.
module multicycle_seq_ctrl
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [6:0]       opcode_i,
   input  logic             memw_i,
   input  logic             memrd_i,
   input  logic             regwrite_i,
   output logic             imem_req_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   input  logic             dmem_gnt_i,
   input  logic             dmem_rvalid_i,
   output logic             ir_we_o,
   output logic             pc_we_o,
   output logic             rf_we_o,
   input  logic             halt_i,
   output logic             halted_o,
   output logic             trap_o,
   output logic [1:0]       trap_cause_o,
   output logic [CNT_W-1:0] instret_o,
   output logic [3:0]       state_o
);

   state_e            state_q, state_d;
   trap_cause_e       cause_q, cause_d;
   logic [CNT_W-1:0]  instret_q, instret_d;

   logic imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
   logic tmo_clr, tmo_en, tmo_expired;

   seq_timeout_cnt #(
      .MAX_CYCLES (MEM_TIMEOUT)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (tmo_clr),
      .en_i      (tmo_en),
      .expired_o (tmo_expired)
   );

   // A completing gnt/rvalid is checked before expiry, so it wins on the last cycle.
   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      instret_d = instret_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      unique case (state_q)
         ST_F_REQ: begin
            if (halt_i) begin
               state_d = ST_HALT;
            end else begin
               imem_req = 1'b1;
               if (imem_gnt_i) begin
                  state_d = ST_F_WAIT;
               end else if (tmo_expired) begin
                  state_d = ST_TRAP;
                  cause_d = CAUSE_IMEM_TO;
               end
            end
         end
         ST_F_WAIT: begin
            if (imem_rvalid_i) begin
               ir_we   = 1'b1;
               state_d = ST_DEC;
            end else if (tmo_expired) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_IMEM_TO;
            end
         end
         ST_DEC: begin
            if (is_legal_opcode(opcode_i)) begin
               state_d = ST_EXEC;
            end else begin
               state_d = ST_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         ST_EXEC: begin
            state_d = (memrd_i || memw_i) ? ST_M_REQ : ST_WB;
         end
         ST_M_REQ: begin
            dmem_req = 1'b1;
            dmem_we  = memw_i;
            if (dmem_gnt_i) begin
               state_d = ST_M_WAIT;
            end else if (tmo_expired) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_DMEM_TO;
            end
         end
         ST_M_WAIT: begin
            if (dmem_rvalid_i) begin
               state_d = ST_WB;
            end else if (tmo_expired) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_DMEM_TO;
            end
         end
         ST_WB: begin
            pc_we     = 1'b1;
            rf_we     = regwrite_i;
            instret_d = instret_q + CNT_W'(1);
            state_d   = ST_F_REQ;
         end
         ST_HALT: begin
            if (!halt_i) begin
               state_d = ST_F_REQ;
            end
         end
         ST_TRAP: begin
            state_d = ST_TRAP;
         end
         default: begin
            state_d = ST_F_REQ;
         end
      endcase
   end

   always_comb begin
      tmo_clr = (state_d != state_q) && ((state_d == ST_F_REQ) || (state_d == ST_M_REQ));
      tmo_en  = ((state_q == ST_F_REQ) && !halt_i) || (state_q == ST_F_WAIT)
             || (state_q == ST_M_REQ) || (state_q == ST_M_WAIT);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_F_REQ;
         cause_q   <= CAUSE_NONE;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         instret_q <= instret_d;
      end
   end

   // Strobes and requests are forced low while reset is asserted, whatever the state.
   assign imem_req_o   = rst_ni & imem_req;
   assign dmem_req_o   = rst_ni & dmem_req;
   assign dmem_we_o    = rst_ni & dmem_we;
   assign ir_we_o      = rst_ni & ir_we;
   assign pc_we_o      = rst_ni & pc_we;
   assign rf_we_o      = rst_ni & rf_we;
   assign halted_o     = (state_q == ST_HALT);
   assign trap_o       = (state_q == ST_TRAP);
   assign trap_cause_o = cause_q;
   assign instret_o    = instret_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Table-driven bench for multicycle_seq_ctrl with a scoreboard queue of expected
// per-cycle outputs, plus hand-written sequences for timeouts, halt and reset.
module tb_multicycle_seq_ctrl;
   import ctrl_pkg::*;

   localparam logic [6:0] R_OPC   = 7'b0110011;
   localparam logic [6:0] LD_OPC  = 7'b0000011;
   localparam logic [6:0] ST_OPC  = 7'b0100011;
   localparam logic [6:0] BAD_OPC = 7'b1111111;

   // outs layout: {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, halted, trap, cause[1:0]}
   localparam logic [9:0] O_NONE   = 10'b000_000_00_00;
   localparam logic [9:0] O_IREQ   = 10'b100_000_00_00;
   localparam logic [9:0] O_DREQ   = 10'b010_000_00_00;
   localparam logic [9:0] O_DREQW  = 10'b011_000_00_00;
   localparam logic [9:0] O_IRWE   = 10'b000_100_00_00;
   localparam logic [9:0] O_WBRF   = 10'b000_011_00_00;
   localparam logic [9:0] O_WB     = 10'b000_010_00_00;
   localparam logic [9:0] O_HALTED = 10'b000_000_10_00;
   localparam logic [9:0] O_TRAP01 = 10'b000_000_01_01;
   localparam logic [9:0] O_TRAP10 = 10'b000_000_01_10;
   localparam logic [9:0] O_TRAP11 = 10'b000_000_01_11;

   // stim layout: {rst_n, halt, imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid, memw, memrd, regwrite}
   typedef struct {
      string       tag;
      logic [6:0]  opc;
      logic [8:0]  stim;
      logic [9:0]  outs;
      state_e      st;
      logic [31:0] ret;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic        memw, memrd, regwrite;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic        ir_we, pc_we, rf_we;
   logic        halt, halted, trap;
   logic [1:0]  trap_cause;
   logic [31:0] instret;
   logic [3:0]  state;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   multicycle_seq_ctrl #(
      .MEM_TIMEOUT (16),
      .CNT_W       (32)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .opcode_i      (opcode),
      .memw_i        (memw),
      .memrd_i       (memrd),
      .regwrite_i    (regwrite),
      .imem_req_o    (imem_req),
      .imem_gnt_i    (imem_gnt),
      .imem_rvalid_i (imem_rvalid),
      .dmem_req_o    (dmem_req),
      .dmem_we_o     (dmem_we),
      .dmem_gnt_i    (dmem_gnt),
      .dmem_rvalid_i (dmem_rvalid),
      .ir_we_o       (ir_we),
      .pc_we_o       (pc_we),
      .rf_we_o       (rf_we),
      .halt_i        (halt),
      .halted_o      (halted),
      .trap_o        (trap),
      .trap_cause_o  (trap_cause),
      .instret_o     (instret),
      .state_o       (state)
   );

   function automatic void addVec(input string tag, input logic [6:0] opc, input logic [8:0] stim,
                                  input logic [9:0] outs, input state_e st, input logic [31:0] ret);
      vec_t v;
      v.tag  = tag;
      v.opc  = opc;
      v.stim = stim;
      v.outs = outs;
      v.st   = st;
      v.ret  = ret;
      tbl.push_back(v);
   endfunction

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rst_n       = v.stim[8];
      halt        = v.stim[7];
      imem_gnt    = v.stim[6];
      imem_rvalid = v.stim[5];
      dmem_gnt    = v.stim[4];
      dmem_rvalid = v.stim[3];
      memw        = v.stim[2];
      memrd       = v.stim[1];
      regwrite    = v.stim[0];
      opcode      = v.opc;
      exp_q.push_back(v);
   endtask

   task automatic checkOutput();
      vec_t       e;
      logic [9:0] act;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_empty: no expected entry queued");
         return;
      end
      e   = exp_q.pop_front();
      act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, halted, trap, trap_cause};
      if (act !== e.outs || state !== e.st || instret !== e.ret) begin
         errors++;
         $display("[TB] FAIL %s: got outs=%b state=%0d instret=%0d, expected outs=%b state=%0d instret=%0d",
                  e.tag, act, state, instret, e.outs, e.st, e.ret);
      end
   endtask

   task automatic step(input string tag, input logic [6:0] opc, input logic [8:0] stim,
                       input logic [9:0] outs, input state_e st, input logic [31:0] ret);
      vec_t v;
      v.tag  = tag;
      v.opc  = opc;
      v.stim = stim;
      v.outs = outs;
      v.st   = st;
      v.ret  = ret;
      applyStimulus(v);
      checkOutput();
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n = 1'b0;
      {halt, imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid, memw, memrd, regwrite} = '0;
      opcode = R_OPC;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      rst_n = 1'b0;
      {halt, imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid, memw, memrd, regwrite} = '0;
      opcode = R_OPC;
      repeat (2) @(posedge clk);

      addVec("reset",        R_OPC,   9'b00_00_00_000, O_NONE,   ST_F_REQ,  0);
      addVec("r_freq",       R_OPC,   9'b10_11_00_001, O_IREQ,   ST_F_REQ,  0);
      addVec("r_fwait",      R_OPC,   9'b10_01_00_001, O_IRWE,   ST_F_WAIT, 0);
      addVec("r_dec",        R_OPC,   9'b10_00_00_001, O_NONE,   ST_DEC,    0);
      addVec("r_exec",       R_OPC,   9'b10_00_00_001, O_NONE,   ST_EXEC,   0);
      addVec("r_wb",         R_OPC,   9'b10_00_00_001, O_WBRF,   ST_WB,     0);
      addVec("ld_freq",      LD_OPC,  9'b10_10_00_011, O_IREQ,   ST_F_REQ,  1);
      addVec("ld_fwait",     LD_OPC,  9'b10_01_00_011, O_IRWE,   ST_F_WAIT, 1);
      addVec("ld_dec",       LD_OPC,  9'b10_00_00_011, O_NONE,   ST_DEC,    1);
      addVec("ld_exec",      LD_OPC,  9'b10_00_00_011, O_NONE,   ST_EXEC,   1);
      addVec("ld_mreq_1",    LD_OPC,  9'b10_00_00_011, O_DREQ,   ST_M_REQ,  1);
      addVec("ld_mreq_2",    LD_OPC,  9'b10_00_00_011, O_DREQ,   ST_M_REQ,  1);
      addVec("ld_mreq_3",    LD_OPC,  9'b10_00_00_011, O_DREQ,   ST_M_REQ,  1);
      addVec("ld_mreq_gnt",  LD_OPC,  9'b10_00_11_011, O_DREQ,   ST_M_REQ,  1);
      addVec("ld_mwait",     LD_OPC,  9'b10_00_00_011, O_NONE,   ST_M_WAIT, 1);
      addVec("ld_mwait_rv",  LD_OPC,  9'b10_00_01_011, O_NONE,   ST_M_WAIT, 1);
      addVec("ld_wb",        LD_OPC,  9'b10_00_00_011, O_WBRF,   ST_WB,     1);
      addVec("st_freq",      ST_OPC,  9'b10_11_00_100, O_IREQ,   ST_F_REQ,  2);
      addVec("st_fwait",     ST_OPC,  9'b10_01_00_100, O_IRWE,   ST_F_WAIT, 2);
      addVec("st_dec",       ST_OPC,  9'b10_00_00_100, O_NONE,   ST_DEC,    2);
      addVec("st_exec",      ST_OPC,  9'b10_00_00_100, O_NONE,   ST_EXEC,   2);
      addVec("st_mreq",      ST_OPC,  9'b10_00_10_100, O_DREQW,  ST_M_REQ,  2);
      addVec("st_mwait",     ST_OPC,  9'b10_00_01_100, O_NONE,   ST_M_WAIT, 2);
      addVec("st_wb",        ST_OPC,  9'b10_00_00_100, O_WB,     ST_WB,     2);
      addVec("halt_freq",    R_OPC,   9'b11_00_00_000, O_NONE,   ST_F_REQ,  3);
      addVec("halt_hold",    R_OPC,   9'b11_00_00_000, O_HALTED, ST_HALT,   3);
      addVec("halt_release", R_OPC,   9'b10_00_00_000, O_HALTED, ST_HALT,   3);
      addVec("bad_freq",     BAD_OPC, 9'b10_10_00_000, O_IREQ,   ST_F_REQ,  3);
      addVec("bad_fwait",    BAD_OPC, 9'b10_01_00_000, O_IRWE,   ST_F_WAIT, 3);
      addVec("bad_dec",      BAD_OPC, 9'b10_00_00_000, O_NONE,   ST_DEC,    3);
      addVec("trap_hold",    BAD_OPC, 9'b10_11_00_000, O_TRAP01, ST_TRAP,   3);
      addVec("trap_halt",    BAD_OPC, 9'b11_00_00_000, O_TRAP01, ST_TRAP,   3);
      addVec("trap_rst",     BAD_OPC, 9'b00_11_00_000, O_TRAP01, ST_TRAP,   3);
      addVec("post_rst",     R_OPC,   9'b10_00_00_000, O_IREQ,   ST_F_REQ,  0);

      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         checkOutput();
      end

      // Fetch granted but data never returns: trap lands 16 cycles after F_REQ entry.
      resetDut();
      step("ito_freq", R_OPC, 9'b10_10_00_000, O_IREQ, ST_F_REQ, 0);
      for (int i = 1; i < 16; i++) step("ito_fwait", R_OPC, 9'b10_00_00_000, O_NONE, ST_F_WAIT, 0);
      step("ito_trap",  R_OPC, 9'b10_10_00_000, O_TRAP10, ST_TRAP, 0);
      step("ito_stuck", R_OPC, 9'b10_00_00_000, O_TRAP10, ST_TRAP, 0);

      // rvalid on the final allowed cycle completes instead of trapping.
      resetDut();
      step("late_freq", R_OPC, 9'b10_10_00_000, O_IREQ, ST_F_REQ, 0);
      for (int i = 1; i < 15; i++) step("late_fwait", R_OPC, 9'b10_00_00_000, O_NONE, ST_F_WAIT, 0);
      step("late_rv",  R_OPC, 9'b10_01_00_000, O_IRWE, ST_F_WAIT, 0);
      step("late_dec", R_OPC, 9'b10_00_00_000, O_NONE, ST_DEC,    0);

      // Data request never granted: trap 16 cycles after M_REQ entry.
      resetDut();
      step("dto_freq",  LD_OPC, 9'b10_10_00_011, O_IREQ, ST_F_REQ,  0);
      step("dto_fwait", LD_OPC, 9'b10_01_00_011, O_IRWE, ST_F_WAIT, 0);
      step("dto_dec",   LD_OPC, 9'b10_00_00_011, O_NONE, ST_DEC,    0);
      step("dto_exec",  LD_OPC, 9'b10_00_00_011, O_NONE, ST_EXEC,   0);
      for (int i = 0; i < 16; i++) step("dto_mreq", LD_OPC, 9'b10_00_00_011, O_DREQ, ST_M_REQ, 0);
      step("dto_trap",  LD_OPC, 9'b10_00_11_011, O_TRAP11, ST_TRAP, 0);

      // Halt raised mid-access: the load retires first, then the sequencer parks.
      resetDut();
      step("hm_freq",    LD_OPC, 9'b10_10_00_011, O_IREQ,   ST_F_REQ,  0);
      step("hm_fwait",   LD_OPC, 9'b10_01_00_011, O_IRWE,   ST_F_WAIT, 0);
      step("hm_dec",     LD_OPC, 9'b10_00_00_011, O_NONE,   ST_DEC,    0);
      step("hm_exec",    LD_OPC, 9'b10_00_00_011, O_NONE,   ST_EXEC,   0);
      step("hm_mreq",    LD_OPC, 9'b10_00_10_011, O_DREQ,   ST_M_REQ,  0);
      step("hm_mwait",   LD_OPC, 9'b11_00_00_011, O_NONE,   ST_M_WAIT, 0);
      step("hm_mwait_rv",LD_OPC, 9'b11_00_01_011, O_NONE,   ST_M_WAIT, 0);
      step("hm_wb",      LD_OPC, 9'b11_00_00_011, O_WBRF,   ST_WB,     0);
      step("hm_freq2",   LD_OPC, 9'b11_00_00_011, O_NONE,   ST_F_REQ,  1);
      step("hm_halted",  LD_OPC, 9'b11_00_00_011, O_HALTED, ST_HALT,   1);
      step("hm_release", LD_OPC, 9'b10_00_00_011, O_HALTED, ST_HALT,   1);
      step("hm_resume",  LD_OPC, 9'b10_00_00_011, O_IREQ,   ST_F_REQ,  1);

      // Reset while waiting on data: counter clears and a stray rvalid is ignored.
      step("rm_freq",    LD_OPC, 9'b10_10_00_011, O_IREQ, ST_F_REQ,  1);
      step("rm_fwait",   LD_OPC, 9'b10_01_00_011, O_IRWE, ST_F_WAIT, 1);
      step("rm_dec",     LD_OPC, 9'b10_00_00_011, O_NONE, ST_DEC,    1);
      step("rm_exec",    LD_OPC, 9'b10_00_00_011, O_NONE, ST_EXEC,   1);
      step("rm_mreq",    LD_OPC, 9'b10_00_10_011, O_DREQ, ST_M_REQ,  1);
      step("rm_mwait",   LD_OPC, 9'b10_00_00_011, O_NONE, ST_M_WAIT, 1);
      step("rm_rst",     LD_OPC, 9'b00_00_00_011, O_NONE, ST_M_WAIT, 1);
      step("rm_stray_1", LD_OPC, 9'b10_00_01_011, O_IREQ, ST_F_REQ,  0);
      step("rm_stray_2", LD_OPC, 9'b10_00_01_011, O_IREQ, ST_F_REQ,  0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
